p_hit_feeder: RTL and testbench



---
 rtl/p_hit_pkg.sv | 19 +
 rtl/p_hit_feeder_lane_issue_tracker.sv | 40 ++++
 rtl/p_hit_feeder.sv | 96 +++++++++
 tb/tb_p_hit_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_hit_pkg.sv
// Shared types for the hit-point feeder slice.
// Q16.16 vector components and the ray/triangle record.
package p_hit_pkg;

    localparam int DATA_W = 32;
    localparam int Q_BITS = 16;
    localparam int LANES  = 4;

    typedef logic signed [DATA_W-1:0] comp_t;
    typedef comp_t [2:0] vec3_t;

    typedef struct packed {
        vec3_t normal;
        vec3_t v0;
        vec3_t origin;
        vec3_t dir;
    } hit_rec_t;

endpackage

// File: rtl/p_hit_feeder_lane_issue_tracker.sv
// Per-lane pending mask for one held record.
// Produces lane strobes, the post-write mask and a done pulse.
module lane_issue_tracker
    import p_hit_pkg::*;
#(
    parameter int NUM_LANES = LANES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [NUM_LANES-1:0] out_full,
    output logic [NUM_LANES-1:0] wr_en,
    output logic [NUM_LANES-1:0] pending,
    output logic [NUM_LANES-1:0] pending_next,
    output logic                 done
);

    logic [NUM_LANES-1:0] pend_q;

    // Pending set: reload on a new record, else drop lanes that wrote.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
        end else if (load) begin
            pend_q <= '1;
        end else begin
            pend_q <= pending_next;
        end
    end

    // Strobe only pending lanes that have room; none while in reset.
    always_comb begin
        wr_en        = pend_q & ~out_full & {NUM_LANES{~reset}};
        pending_next = pend_q & ~wr_en;
        done         = ~reset & (|pend_q) & ~(|pending_next);
    end

    assign pending = pend_q;

endmodule

// File: rtl/p_hit_feeder.sv
// Hit-point stage front end: pop one record, fan it out to
// independent write lanes, pop the next once all lanes took it.
module p_hit_feeder
    import p_hit_pkg::*;
#(
    parameter int NUM_LANES = LANES,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_empty,
    output logic                    in_rd_en,
    input  logic [2:0][DATA_W-1:0]  in_tri_normal,
    input  logic [2:0][DATA_W-1:0]  in_v0,
    input  logic [2:0][DATA_W-1:0]  in_origin,
    input  logic [2:0][DATA_W-1:0]  in_dir,
    output logic [2:0][DATA_W-1:0]  tri_normal_1,
    output logic [2:0][DATA_W-1:0]  tri_normal_2,
    output logic [2:0][DATA_W-1:0]  v0,
    output logic [2:0][DATA_W-1:0]  origin_1,
    output logic [2:0][DATA_W-1:0]  origin_2,
    output logic [2:0][DATA_W-1:0]  dir_1,
    output logic [2:0][DATA_W-1:0]  dir_2,
    output logic [NUM_LANES-1:0]    out_wr_en,
    input  logic [NUM_LANES-1:0]    out_full,
    output logic                    busy,
    output logic [CNT_W-1:0]        issued_count
);

    typedef struct packed {
        logic [2:0][DATA_W-1:0] normal;
        logic [2:0][DATA_W-1:0] vtx;
        logic [2:0][DATA_W-1:0] origin;
        logic [2:0][DATA_W-1:0] dir;
    } rec_t;

    rec_t                 hold_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] pending_next;
    logic                 done;
    logic                 pop;

    lane_issue_tracker #(
        .NUM_LANES(NUM_LANES)
    ) u_tracker (
        .clock       (clock),
        .reset       (reset),
        .load        (pop),
        .out_full    (out_full),
        .wr_en       (out_wr_en),
        .pending     (pending),
        .pending_next(pending_next),
        .done        (done)
    );

    // Pop when idle or when the last owed lanes write this cycle.
    always_comb begin
        pop = ~reset & ~in_empty & ~(|pending_next);
    end

    // Holding register: capture the show-ahead head on pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q.normal <= in_tri_normal;
            hold_q.vtx    <= in_v0;
            hold_q.origin <= in_origin;
            hold_q.dir    <= in_dir;
        end
    end

    // Count records that finished on every lane; wraps freely.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_rd_en     = pop;
    assign busy         = |pending;
    assign issued_count = cnt_q;

    assign tri_normal_1 = hold_q.normal;
    assign tri_normal_2 = hold_q.normal;
    assign v0           = hold_q.vtx;
    assign origin_1     = hold_q.origin;
    assign origin_2     = hold_q.origin;
    assign dir_1        = hold_q.dir;
    assign dir_2        = hold_q.dir;

endmodule

// File: tb/tb_p_hit_feeder.sv
// Bench for p_hit_feeder: vector tables, corner sequences and
// random traffic against a record/lane-delivery reference model.
module tb_p_hit_feeder;
    import p_hit_pkg::*;

    localparam int NL = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_empty;
    logic          in_rd_en;
    vec3_t         in_tri_normal, in_v0, in_origin, in_dir;
    vec3_t         tri_normal_1, tri_normal_2, v0;
    vec3_t         origin_1, origin_2, dir_1, dir_2;
    logic [NL-1:0] out_wr_en, out_full;
    logic          busy;
    logic [CW-1:0] issued_count;

    always #5 clock = ~clock;

    p_hit_feeder #(
        .NUM_LANES(NL),
        .DATA_W   (32),
        .CNT_W    (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_empty     (in_empty),
        .in_rd_en     (in_rd_en),
        .in_tri_normal(in_tri_normal),
        .in_v0        (in_v0),
        .in_origin    (in_origin),
        .in_dir       (in_dir),
        .tri_normal_1 (tri_normal_1),
        .tri_normal_2 (tri_normal_2),
        .v0           (v0),
        .origin_1     (origin_1),
        .origin_2     (origin_2),
        .dir_1        (dir_1),
        .dir_2        (dir_2),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .busy         (busy),
        .issued_count (issued_count)
    );

    typedef struct packed {
        logic [NL-1:0] full;
        logic          rst;
        logic [NL-1:0] wr;
        logic          rd;
        logic          bsy;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    hit_rec_t      fifo[$];
    hit_rec_t      sent[$];
    hit_rec_t      lane_log[NL][$];
    vec_t          tab[$];
    hit_rec_t      cur;
    logic [NL-1:0] owed;
    int            cnt;
    logic [NL-1:0] obs_wr;
    logic          obs_rd;
    logic          obs_busy;

    task automatic chk(input string nm, input logic [383:0] act,
                       input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec3_t v3(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z);
        vec3_t v;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        return v;
    endfunction

    function automatic hit_rec_t rand_rec();
        hit_rec_t r;
        r.normal = v3($urandom, $urandom, $urandom);
        r.v0     = v3($urandom, $urandom, $urandom);
        r.origin = v3($urandom, $urandom, $urandom);
        r.dir    = v3($urandom, $urandom, $urandom);
        return r;
    endfunction

    // One clock: drive, compare at negedge, advance the model.
    task automatic tick(input logic [NL-1:0] full_v, input logic rst);
        logic [NL-1:0] exp_wr, rem;
        logic          exp_rd;
        hit_rec_t      r1, r2;
        reset    = rst;
        out_full = full_v;
        in_empty = (fifo.size() == 0);
        if (fifo.size() != 0) begin
            in_tri_normal = fifo[0].normal;
            in_v0         = fifo[0].v0;
            in_origin     = fifo[0].origin;
            in_dir        = fifo[0].dir;
        end
        @(negedge clock);
        exp_wr = rst ? '0 : (owed & ~full_v);
        rem    = owed & ~exp_wr;
        exp_rd = !rst && fifo.size() != 0 && rem == '0;
        obs_wr   = out_wr_en;
        obs_rd   = in_rd_en;
        obs_busy = busy;
        r1.normal = tri_normal_1;
        r1.v0     = v0;
        r1.origin = origin_1;
        r1.dir    = dir_1;
        r2.normal = tri_normal_2;
        r2.v0     = v0;
        r2.origin = origin_2;
        r2.dir    = dir_2;
        chk("wr_en", out_wr_en, exp_wr);
        chk("rd_en", in_rd_en, exp_rd);
        chk("busy", busy, owed != '0);
        chk("rec_copy1", r1, cur);
        chk("rec_copy2", r2, cur);
        chk("issued_count", issued_count, cnt % (1 << CW));
        for (int i = 0; i < NL; i++)
            if (out_wr_en[i]) lane_log[i].push_back(r1);
        if (rst) begin
            owed = '0;
            cur  = '0;
            cnt  = 0;
            sent.delete();
            for (int i = 0; i < NL; i++) lane_log[i].delete();
        end else begin
            if (owed != '0 && rem == '0) cnt++;
            if (exp_rd) begin
                cur = fifo.pop_front();
                sent.push_back(cur);
                owed = '1;
            end else begin
                owed = rem;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic [NL-1:0] f, input logic r,
                       input logic [NL-1:0] w, input logic rd,
                       input logic b);
        vec_t v;
        v.full = f;
        v.rst  = r;
        v.wr   = w;
        v.rd   = rd;
        v.bsy  = b;
        tab.push_back(v);
    endtask

    task automatic run_tab(input string nm);
        foreach (tab[k]) begin
            tick(tab[k].full, tab[k].rst);
            chk($sformatf("%s[%0d].wr", nm, k), obs_wr, tab[k].wr);
            chk($sformatf("%s[%0d].rd", nm, k), obs_rd, tab[k].rd);
            chk($sformatf("%s[%0d].busy", nm, k), obs_busy, tab[k].bsy);
        end
        tab.delete();
    endtask

    // Every lane must have received each popped record once, in order.
    task automatic verify_logs(input string nm);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("%s.lane%0d_n", nm, i),
                lane_log[i].size(), sent.size());
            if (lane_log[i].size() == sent.size())
                for (int k = 0; k < sent.size(); k++)
                    chk($sformatf("%s.lane%0d_rec%0d", nm, i, k),
                        lane_log[i][k], sent[k]);
            lane_log[i].delete();
        end
        sent.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((owed != '0 || fifo.size() != 0) && n < 200) begin
            tick('0, 1'b0);
            n++;
        end
        chk("drain_bounded", n < 200, 1'b1);
    endtask

    initial begin
        hit_rec_t a;
        int       rd_n, wr_n;
        reset         = 1'b1;
        out_full      = '0;
        in_empty      = 1'b1;
        in_tri_normal = '0;
        in_v0         = '0;
        in_origin     = '0;
        in_dir        = '0;
        cur  = '0;
        owed = '0;
        cnt  = 0;
        repeat (2) @(posedge clock);
        #1;

        // reset state, idle with empty upstream
        tick('0, 1'b0);
        chk("reset_count", issued_count, 0);

        // single record
        a.normal = v3(0, 0, 32'h0001_0000);
        a.v0     = v3(32'h0002_0000, 0, 0);
        a.origin = '0;
        a.dir    = v3(0, 0, 32'hFFFF_0000);
        fifo.push_back(a);
        add(4'b0000, 0, 4'b0000, 1, 0);
        add(4'b0000, 0, 4'b1111, 0, 1);
        add(4'b0000, 0, 4'b0000, 0, 0);
        run_tab("single");
        chk("single_count", issued_count, 1);
        verify_logs("single");

        // back-to-back
        for (int i = 0; i < 8; i++) fifo.push_back(rand_rec());
        rd_n = 0;
        wr_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick('0, 1'b0);
            rd_n += int'(obs_rd);
            wr_n += int'(obs_wr == 4'b1111);
        end
        chk("b2b_pops", rd_n, 8);
        chk("b2b_writes", wr_n, 8);
        chk("b2b_count", issued_count, 9);
        verify_logs("b2b");

        // lane 2 stalled for 5 cycles
        fifo.push_back(rand_rec());
        fifo.push_back(rand_rec());
        add(4'b0000, 0, 4'b0000, 1, 0);
        for (int i = 0; i < 5; i++)
            add(4'b0100, 0, (i == 0) ? 4'b1011 : 4'b0000, 0, 1);
        add(4'b0000, 0, 4'b0100, 1, 1);
        add(4'b0000, 0, 4'b1111, 0, 1);
        add(4'b0000, 0, 4'b0000, 0, 0);
        run_tab("stall");
        chk("stall_count", issued_count, 11);
        verify_logs("stall");

        // staggered full
        fifo.push_back(rand_rec());
        fifo.push_back(rand_rec());
        add(4'b0000, 0, 4'b0000, 1, 0);
        add(4'b0011, 0, 4'b1100, 0, 1);
        add(4'b0010, 0, 4'b0001, 0, 1);
        add(4'b0000, 0, 4'b0010, 1, 1);
        add(4'b0000, 0, 4'b1111, 0, 1);
        add(4'b0000, 0, 4'b0000, 0, 0);
        run_tab("stagger");
        chk("stagger_count", issued_count, 13);
        verify_logs("stagger");

        // reset with lane 2 still owed
        fifo.push_back(rand_rec());
        add(4'b0000, 0, 4'b0000, 1, 0);
        add(4'b0100, 0, 4'b1011, 0, 1);
        add(4'b0100, 1, 4'b0000, 0, 1);
        add(4'b0000, 0, 4'b0000, 0, 0);
        run_tab("rst_mid");
        chk("rst_mid_count", issued_count, 0);
        fifo.push_back(rand_rec());
        add(4'b0000, 0, 4'b0000, 1, 0);
        add(4'b0000, 0, 4'b1111, 0, 1);
        add(4'b0000, 0, 4'b0000, 0, 0);
        run_tab("post_rst");
        chk("post_rst_count", issued_count, 1);
        verify_logs("post_rst");

        // counter wrap: 17 records on a 4-bit counter
        tick('0, 1'b1);
        for (int i = 0; i < 17; i++) fifo.push_back(rand_rec());
        drain();
        tick('0, 1'b0);
        chk("wrap_count", issued_count, 1);
        verify_logs("wrap");

        // random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            logic [NL-1:0] f;
            if ($urandom_range(0, 2) != 0 && fifo.size() < 6)
                fifo.push_back(rand_rec());
            for (int i = 0; i < NL; i++) f[i] = ($urandom_range(0, 2) == 0);
            tick(f, ($urandom_range(0, 149) == 0));
        end
        drain();
        verify_logs("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
